// File: rtl/mux_seq_n.sv
// mux_seq_n: parametrised N:1 channel selector with a capture bank.
// SCAN mode snapshots every input channel and streams them out one beat
// per accepted handshake (idx 0..N_IN-1). DIRECT mode returns one
// registered channel chosen by sel, flagging sel >= N_IN as an error.
//
// Handshake: a beat transfers on a rising clk edge where valid & ready are
// both high. The producer never drops valid, and never changes data while
// valid is high and ready is low, until that transfer happens.
// Synchronous reset is the only exception.
module mux_seq_n #(
  parameter int WIDTH = 16,
  parameter int N_IN  = 9,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_IN*WIDTH-1:0] in_bus,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  sel_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

  // Current FSM state; kept as a plain named register so checkers can bind to it.
  logic [1:0] state;

  // Snapshot of all channels taken on a SCAN accept.
  logic [WIDTH-1:0] bank [N_IN];

  logic [31:0]      sel_ext;
  logic             sel_ok;
  logic [WIDTH-1:0] direct_word;
  logic [SEL_W-1:0] nxt_idx;
  logic             accept;
  logic             beat_done;

  assign sel_ext   = 32'(sel);
  assign sel_ok    = (sel_ext < 32'(N_IN));
  assign nxt_idx   = out_idx + 1'b1;
  assign accept    = in_valid & in_ready;
  assign beat_done = out_valid & out_ready;

  // Request acceptance depends on state only, held low during reset.
  assign in_ready = rst_n && (state == ST_IDLE);

  // DIRECT channel mux; guarded so an out-of-range sel never indexes past in_bus.
  always_comb begin
    direct_word = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (sel_ext == 32'(k)) direct_word = in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Capture bank: cleared on reset, loaded with every channel on a SCAN accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_IN; k++) bank[k] <= '0;
    end else if (accept && !mode) begin
      for (int k = 0; k < N_IN; k++) bank[k] <= in_bus[k*WIDTH +: WIDTH];
    end
  end

  // Control FSM and registered output stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            out_valid <= 1'b1;
            if (!mode) begin
              // Beat 0 comes straight from the bus, the same value the bank captures.
              out_data <= in_bus[WIDTH-1:0];
              out_idx  <= '0;
              out_last <= 1'b0;
              sel_err  <= 1'b0;
              state    <= ST_SCAN;
            end else begin
              out_data <= sel_ok ? direct_word : '0;
              out_idx  <= sel;
              out_last <= 1'b1;
              sel_err  <= ~sel_ok;
              state    <= ST_HOLD;
            end
          end
        end
        ST_SCAN: begin
          if (beat_done) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              out_idx  <= nxt_idx;
              out_data <= bank[nxt_idx];
              out_last <= (nxt_idx == LAST_IDX);
            end
          end
        end
        ST_HOLD: begin
          if (beat_done) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sel_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          sel_err   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mux_seq_n.md
Name: mux_seq_n

Overview:
Parametrised N:1 channel selector with an internal capture bank and valid/ready output stream. It generalises the fixed 9:1 16-bit selector in the autoencoder datapath. In SCAN mode it snapshots all N input words and serialises them, one per accepted beat, to the MAC/activation stage. In DIRECT mode it returns one registered word chosen by `sel`, with explicit out-of-range error reporting instead of holding the previous value.

Parameters:
WIDTH, 16, bit width of each data word (Q-format fixed point; never interpreted arithmetically).
N_IN, 9, number of input channels; legal range 2..64.
SEL_W, $clog2(N_IN), width of `sel` and `out_idx`.

Ports:
clk  input  1  clock; all logic rising-edge.
rst_n  input  1  synchronous active-low reset.
in_bus  input  N_IN*WIDTH  flattened inputs; channel k = in_bus[k*WIDTH +: WIDTH].
in_valid  input  1  request; in_bus/mode/sel are valid.
in_ready  output  1  block can accept a request.
mode  input  1  0 = SCAN, 1 = DIRECT; sampled only on the accept cycle.
sel  input  SEL_W  DIRECT channel index; sampled only on the accept cycle.
out_data  output  WIDTH  registered output word.
out_idx  output  SEL_W  channel index of out_data.
out_valid  output  1  out_data/out_idx/out_last/sel_err are valid.
out_ready  input  1  downstream accepts the beat.
out_last  output  1  final beat of the current request.
sel_err  output  1  DIRECT request had sel >= N_IN.

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - State goes to IDLE; bank is cleared to 0.
  - out_data = 0, out_idx = 0, out_valid = 0, out_last = 0, sel_err = 0.
  - in_ready = 0 while rst_n = 0.
  - Reset overrides everything, including mid-SCAN: the in-flight request is aborted and no further beats are emitted.
- States: IDLE, SCAN, HOLD.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - Accept occurs when in_valid & in_ready. On accept:
  - mode = 0: capture all N_IN words into the bank and go to SCAN. Next cycle: out_data = bank[0], out_idx = 0, out_valid = 1.
  - mode = 1, sel < N_IN: out_data = in_bus channel sel, out_idx = sel, out_last = 1, sel_err = 0, go to HOLD.
  - mode = 1, sel >= N_IN: out_data = 0, out_idx = sel, out_last = 1, sel_err = 1, go to HOLD.
  - Latency: the first out_valid appears exactly 1 cycle after the accept cycle.
- SCAN:
  - in_ready = 0, out_valid = 1, out_last = (out_idx == N_IN-1).
  - out_valid & out_ready with out_last = 0: out_idx increments; out_data = bank[out_idx+1] on the next cycle.
  - out_valid & out_ready with out_last = 1: go to IDLE, out_valid = 0, out_last = 0.
  - out_ready = 0: all outputs hold stable (no change of data or idx while stalled).
  - in_bus changes during SCAN have no effect; the bank is the source.
- HOLD:
  - in_ready = 0, out_valid = 1; all outputs hold until out_ready.
  - On out_ready: go to IDLE, out_valid = 0, out_last = 0, sel_err = 0.
- No accept in the same cycle as a final beat: in_ready is 0 in SCAN/HOLD. Minimum request spacing is N_IN+1 cycles (SCAN) or 2 cycles (DIRECT) with out_ready held high.
- Throughput: one beat per cycle in SCAN with out_ready held high.
- Request length: a SCAN request produces exactly N_IN beats, idx 0..N_IN-1 in order, with no skips or duplicates.
- Registered path: no combinational path from in_bus or out_ready to out_data, out_idx or out_last. in_ready depends on state only.
- Width rules: out_idx is zero-extended to SEL_W; `sel` is compared unsigned against N_IN.
- Handshake protocol: stalls follow standard valid/ready rules. Once asserted, out_valid is never deasserted before the handshake completes, except by reset.

Test Plan:
1. Reset then SCAN, default params, in_bus channel k = 16'h1000+k, out_ready = 1 → 9 consecutive beats, data 1000..1008, idx 0..8; out_last only on idx 8; out_valid falls next cycle; in_ready returns 1.
2. SCAN with out_ready toggling 1,0,0,1,… and in_bus changed to all 16'hFFFF after accept → data/idx frozen during stalls; still 1000..1008 in order; no lost or duplicated beats.
3. DIRECT, sel = 4, channel 4 = 16'hBEEF → one beat: data BEEF, idx 4, out_last = 1, sel_err = 0. Hold out_ready = 0 for 3 cycles → outputs stable, in_ready = 0.
4. DIRECT, sel = 12 (N_IN = 9, SEL_W = 4) → one beat: data 0, idx 12, sel_err = 1, out_last = 1. Next accepted request shows sel_err = 0.
5. Assert rst_n = 0 for 1 cycle at beat idx 3 of a SCAN → next cycle out_valid = 0, in_ready = 0; after release in_ready = 1. A new SCAN restarts at idx 0 with the freshly captured data.
6. Re-parameterise WIDTH = 8, N_IN = 4 (SEL_W = 2): SCAN → 4 beats, out_last on idx 3. DIRECT sel = 3 → channel 3 returned, sel_err = 0.
